// File: rtl/mano_pkg.sv
// mano_pkg: shared encodings for the basic-computer control unit.
//   - ALU operation codes driven on alu_op
//   - bus source codes driven on bus_sel
//   - memory-reference opcodes held in IR[14:12]
//   - bit positions of the register-reference and I/O micro-ops in IR[11:0]
//   - msbIndex(): picks the highest-numbered set reference bit
//   - ctrl_t: the bundle of per-cycle control strobes
package mano_pkg;

  typedef enum logic [2:0] {
    ALU_AND     = 3'd0,
    ALU_ADD     = 3'd1,
    ALU_PASS_DR = 3'd2,
    ALU_CMA     = 3'd3,
    ALU_CIR     = 3'd4,
    ALU_CIL     = 3'd5,
    ALU_CLA     = 3'd6,
    ALU_INC     = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_e;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_RIO = 3'd7
  } opcode_e;

  // Register-reference micro-op bit positions in IR[11:0]
  localparam logic [3:0] RR_CLA = 4'd11;
  localparam logic [3:0] RR_CLE = 4'd10;
  localparam logic [3:0] RR_CMA = 4'd9;
  localparam logic [3:0] RR_CME = 4'd8;
  localparam logic [3:0] RR_CIR = 4'd7;
  localparam logic [3:0] RR_CIL = 4'd6;
  localparam logic [3:0] RR_INC = 4'd5;
  localparam logic [3:0] RR_SPA = 4'd4;
  localparam logic [3:0] RR_SNA = 4'd3;
  localparam logic [3:0] RR_SZA = 4'd2;
  localparam logic [3:0] RR_SZE = 4'd1;
  localparam logic [3:0] RR_HLT = 4'd0;

  // I/O micro-op bit positions in IR[11:0]
  localparam logic [3:0] IO_INP = 4'd11;
  localparam logic [3:0] IO_OUT = 4'd10;
  localparam logic [3:0] IO_SKI = 4'd9;
  localparam logic [3:0] IO_SKO = 4'd8;
  localparam logic [3:0] IO_ION = 4'd7;
  localparam logic [3:0] IO_IOF = 4'd6;

  // Last legal sequence count (T6)
  localparam int SC_LAST = 6;

  // Index returned by msbIndex when no reference bit is set
  localparam logic [3:0] BIT_NONE = 4'hF;

  typedef struct packed {
    logic [2:0] aluOp;
    logic       aluEn;
    logic [2:0] busSel;
    logic       ldAr;
    logic       inrAr;
    logic       ldPc;
    logic       inrPc;
    logic       ldDr;
    logic       inrDr;
    logic       ldAc;
    logic       ldIr;
    logic       ldAcInpr;
    logic       ldOutr;
    logic       clrFgi;
    logic       clrFgo;
    logic       clrE;
    logic       cmpE;
    logic       memRd;
    logic       memWr;
  } ctrl_t;

  // Highest-numbered set bit wins when several micro-op bits are set
  function automatic logic [3:0] msbIndex(input logic [11:0] bits);
    logic [3:0] idx;
    idx = BIT_NONE;
    for (int k = 0; k < 12; k++) begin
      if (bits[k]) idx = 4'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mano_seq_counter.sv
// mano_seq_counter: sequence counter SC for the basic-computer control unit.
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset (SC <= 0)
//   i_inc    advance SC by one
//   i_clr    return SC to 0 (end of instruction)
//   i_hold   freeze SC (halted machine)
//   o_sc     current count
//   o_t      one-hot decode T0..T6 (all zero for an out-of-range count)
module mano_seq_counter
  import mano_pkg::*;
#(
  parameter int SC_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_inc,
  input  logic            i_clr,
  input  logic            i_hold,
  output logic [SC_W-1:0] o_sc,
  output logic [6:0]      o_t
);

  logic [SC_W-1:0] r_sc;

  // An out-of-range count is recovered to T0 before anything else acts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sc <= '0;
    end else if (r_sc > SC_W'(SC_LAST)) begin
      r_sc <= '0;
    end else if (i_clr) begin
      r_sc <= '0;
    end else if (i_hold) begin
      r_sc <= r_sc;
    end else if (i_inc) begin
      r_sc <= r_sc + SC_W'(1);
    end
  end

  always_comb begin
    o_t = '0;
    for (int k = 0; k <= SC_LAST; k++) begin
      o_t[k] = (r_sc == SC_W'(k));
    end
  end

  assign o_sc = r_sc;

endmodule

// File: rtl/mano_control_unit.sv
// mano_control_unit: timing and control sequencer for the basic computer.
// Runs fetch / decode / execute over T0..T6 and decodes IR into ALU, bus,
// register, memory and I/O strobes. All strobes are decodes of SC, the
// latched I bit and IR plus the status inputs.
// Optional feature macro: MANO_INTERRUPT_EN (adds ien/r flops, the RT0..RT2
// interrupt cycle and the ld_tr / clr_pc strobes it needs).
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   ir                     instruction register [15]=I [14:12]=op [11:0]=ref
//   ac_sign, ac_zero       AC status
//   dr_zero, e_flag        DR zero, E flip-flop
//   fgi, fgo               input/output ready flags
//   alu_op, alu_en         ALU operation and result-valid
//   bus_sel                common-bus source
//   ld_*/inr_*             register load / increment strobes
//   ld_ac_inpr, ld_outr    I/O transfer strobes
//   clr_fgi, clr_fgo       I/O flag clears
//   clr_e, cmp_e           E-flag clear / complement
//   mem_rd, mem_wr         memory strobes
//   sc                     current sequence count
//   halted                 sticky halt indicator
module mano_control_unit
  import mano_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int SC_W   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     ir,
  input  logic            ac_sign,
  input  logic            ac_zero,
  input  logic            dr_zero,
  input  logic            e_flag,
  input  logic            fgi,
  input  logic            fgo,
  output logic [2:0]      alu_op,
  output logic            alu_en,
  output logic [2:0]      bus_sel,
  output logic            ld_ar,
  output logic            inr_ar,
  output logic            ld_pc,
  output logic            inr_pc,
  output logic            ld_dr,
  output logic            inr_dr,
  output logic            ld_ac,
  output logic            ld_ir,
  output logic            ld_ac_inpr,
  output logic            ld_outr,
  output logic            clr_fgi,
  output logic            clr_fgo,
  output logic            clr_e,
  output logic            cmp_e,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [SC_W-1:0] sc,
  output logic            halted
`ifdef MANO_INTERRUPT_EN
  ,
  output logic            ld_tr,
  output logic            clr_pc
`endif
);

  logic [SC_W-1:0]   w_sc;
  logic [6:0]        w_t;
  logic [6:0]        w_phase;
  logic [2:0]        w_op;
  logic              w_memRef;
  logic [ADDR_W-1:0] w_refBits;
  logic [3:0]        w_bit;
  ctrl_t             w_ctrl;
  logic              w_clr;
  logic              w_setHalt;
  logic              w_latchI;

  logic r_iBit;
  logic r_halted;

`ifdef MANO_INTERRUPT_EN
  logic r_ien;
  logic r_r;
  logic w_intActive;
  logic w_ionSet;
  logic w_iofSet;
  logic w_intDone;
  logic w_ldTr;
  logic w_clrPc;
`endif

  mano_seq_counter #(
    .SC_W (SC_W)
  ) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (1'b1),
    .i_clr  (w_clr),
    .i_hold (r_halted),
    .o_sc   (w_sc),
    .o_t    (w_t)
  );

  // While reset is held the decode shows T0, so an abandoned instruction
  // cannot fire its strobes on the reset edge
  assign w_phase   = rst_n ? w_t : 7'b0000001;
  assign w_op      = ir[14:12];
  assign w_memRef  = (w_op != OP_RIO);
  assign w_refBits = ir[ADDR_W-1:0];
  assign w_bit     = msbIndex(w_refBits);

`ifdef MANO_INTERRUPT_EN
  assign w_intActive = r_r & rst_n & ~r_halted;
`endif

  always_comb begin
    w_ctrl    = '0;
    w_clr     = 1'b0;
    w_setHalt = 1'b0;
    w_latchI  = 1'b0;
`ifdef MANO_INTERRUPT_EN
    w_ionSet  = 1'b0;
    w_iofSet  = 1'b0;
    w_intDone = 1'b0;
    w_ldTr    = 1'b0;
    w_clrPc   = 1'b0;
`endif
    if (rst_n && r_halted) begin
      // halted: every strobe stays low until reset
    end
`ifdef MANO_INTERRUPT_EN
    // Interrupt cycle replaces fetch: AR is loaded from the idle bus (0)
    else if (w_intActive && w_phase[0]) begin
      w_ctrl.busSel = BUS_NONE;
      w_ctrl.ldAr   = 1'b1;
      w_ldTr        = 1'b1;
    end else if (w_intActive && w_phase[1]) begin
      w_ctrl.busSel = BUS_TR;
      w_ctrl.memWr  = 1'b1;
      w_clrPc       = 1'b1;
    end else if (w_intActive && w_phase[2]) begin
      w_ctrl.inrPc  = 1'b1;
      w_intDone     = 1'b1;
      w_clr         = 1'b1;
    end
`endif
    else if (w_phase[0]) begin
      w_ctrl.busSel = BUS_PC;
      w_ctrl.ldAr   = 1'b1;
    end else if (w_phase[1]) begin
      w_ctrl.memRd  = 1'b1;
      w_ctrl.busSel = BUS_MEM;
      w_ctrl.ldIr   = 1'b1;
      w_ctrl.inrPc  = 1'b1;
    end else if (w_phase[2]) begin
      w_latchI      = 1'b1;
      w_ctrl.busSel = BUS_IR;
      w_ctrl.ldAr   = 1'b1;
    end else if (w_phase[3]) begin
      if (w_memRef) begin
        if (r_iBit) begin
          w_ctrl.memRd  = 1'b1;
          w_ctrl.busSel = BUS_MEM;
          w_ctrl.ldAr   = 1'b1;
        end
      end else if (!r_iBit) begin
        w_clr = 1'b1;
        case (w_bit)
          RR_CLA: begin w_ctrl.aluOp = ALU_CLA; w_ctrl.aluEn = 1'b1; w_ctrl.ldAc = 1'b1; end
          RR_CLE: w_ctrl.clrE = 1'b1;
          RR_CMA: begin w_ctrl.aluOp = ALU_CMA; w_ctrl.aluEn = 1'b1; w_ctrl.ldAc = 1'b1; end
          RR_CME: w_ctrl.cmpE = 1'b1;
          RR_CIR: begin w_ctrl.aluOp = ALU_CIR; w_ctrl.aluEn = 1'b1; w_ctrl.ldAc = 1'b1; end
          RR_CIL: begin w_ctrl.aluOp = ALU_CIL; w_ctrl.aluEn = 1'b1; w_ctrl.ldAc = 1'b1; end
          RR_INC: begin w_ctrl.aluOp = ALU_INC; w_ctrl.aluEn = 1'b1; w_ctrl.ldAc = 1'b1; end
          RR_SPA: w_ctrl.inrPc = ~ac_sign;
          RR_SNA: w_ctrl.inrPc = ac_sign;
          RR_SZA: w_ctrl.inrPc = ac_zero;
          RR_SZE: w_ctrl.inrPc = ~e_flag;
          RR_HLT: w_setHalt = 1'b1;
          default: ;
        endcase
      end else begin
        // I/O uses the same highest-bit-wins rule, so one bus source at most
        w_clr = 1'b1;
        case (w_bit)
          IO_INP: begin w_ctrl.ldAcInpr = 1'b1; w_ctrl.clrFgi = 1'b1; end
          IO_OUT: begin
            w_ctrl.busSel = BUS_AC;
            w_ctrl.ldOutr = 1'b1;
            w_ctrl.clrFgo = 1'b1;
          end
          IO_SKI: w_ctrl.inrPc = fgi;
          IO_SKO: w_ctrl.inrPc = fgo;
`ifdef MANO_INTERRUPT_EN
          IO_ION: w_ionSet = 1'b1;
          IO_IOF: w_iofSet = 1'b1;
`endif
          default: ;
        endcase
      end
    end else if (w_phase[4]) begin
      case (w_op)
        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
          w_ctrl.memRd  = 1'b1;
          w_ctrl.busSel = BUS_MEM;
          w_ctrl.ldDr   = 1'b1;
        end
        OP_STA: begin
          w_ctrl.busSel = BUS_AC;
          w_ctrl.memWr  = 1'b1;
          w_clr         = 1'b1;
        end
        OP_BUN: begin
          w_ctrl.busSel = BUS_AR;
          w_ctrl.ldPc   = 1'b1;
          w_clr         = 1'b1;
        end
        OP_BSA: begin
          w_ctrl.busSel = BUS_PC;
          w_ctrl.memWr  = 1'b1;
          w_ctrl.inrAr  = 1'b1;
        end
        default: w_clr = 1'b1;
      endcase
    end else if (w_phase[5]) begin
      case (w_op)
        OP_AND: begin w_ctrl.aluOp = ALU_AND;     w_ctrl.aluEn = 1'b1; w_ctrl.ldAc = 1'b1; w_clr = 1'b1; end
        OP_ADD: begin w_ctrl.aluOp = ALU_ADD;     w_ctrl.aluEn = 1'b1; w_ctrl.ldAc = 1'b1; w_clr = 1'b1; end
        OP_LDA: begin w_ctrl.aluOp = ALU_PASS_DR; w_ctrl.aluEn = 1'b1; w_ctrl.ldAc = 1'b1; w_clr = 1'b1; end
        OP_BSA: begin
          w_ctrl.busSel = BUS_AR;
          w_ctrl.ldPc   = 1'b1;
          w_clr         = 1'b1;
        end
        OP_ISZ: w_ctrl.inrDr = 1'b1;
        default: w_clr = 1'b1;
      endcase
    end else if (w_phase[6]) begin
      w_clr = 1'b1;
      if (w_op == OP_ISZ) begin
        w_ctrl.busSel = BUS_DR;
        w_ctrl.memWr  = 1'b1;
        w_ctrl.inrPc  = dr_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_iBit   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      if (w_latchI) r_iBit <= ir[15];
      if (w_setHalt) r_halted <= 1'b1;
    end
  end

`ifdef MANO_INTERRUPT_EN
  // A request is only taken outside fetch, so it is recognised at the next T0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ien <= 1'b0;
      r_r   <= 1'b0;
    end else begin
      if (w_ionSet) r_ien <= 1'b1;
      if (w_iofSet) r_ien <= 1'b0;
      if (w_intDone) begin
        r_ien <= 1'b0;
        r_r   <= 1'b0;
      end else if (!(w_phase[0] || w_phase[1] || w_phase[2]) && r_ien &&
                   (fgi || fgo) && !r_halted) begin
        r_r <= 1'b1;
      end
    end
  end

  assign ld_tr  = w_ldTr;
  assign clr_pc = w_clrPc;
`endif

  assign alu_op     = w_ctrl.aluOp;
  assign alu_en     = w_ctrl.aluEn;
  assign bus_sel    = w_ctrl.busSel;
  assign ld_ar      = w_ctrl.ldAr;
  assign inr_ar     = w_ctrl.inrAr;
  assign ld_pc      = w_ctrl.ldPc;
  assign inr_pc     = w_ctrl.inrPc;
  assign ld_dr      = w_ctrl.ldDr;
  assign inr_dr     = w_ctrl.inrDr;
  assign ld_ac      = w_ctrl.ldAc;
  assign ld_ir      = w_ctrl.ldIr;
  assign ld_ac_inpr = w_ctrl.ldAcInpr;
  assign ld_outr    = w_ctrl.ldOutr;
  assign clr_fgi    = w_ctrl.clrFgi;
  assign clr_fgo    = w_ctrl.clrFgo;
  assign clr_e      = w_ctrl.clrE;
  assign cmp_e      = w_ctrl.cmpE;
  assign mem_rd     = w_ctrl.memRd;
  assign mem_wr     = w_ctrl.memWr;
  assign sc         = w_sc;
  assign halted     = r_halted;

endmodule

// File: tb/tb_mano_control_unit.sv
// tb_mano_control_unit: directed self-checking bench for mano_control_unit.
// Inputs change and outputs are sampled in the low half of the clock.
module tb_mano_control_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] ir;
  logic        ac_sign, ac_zero, dr_zero, e_flag, fgi, fgo;
  logic [2:0]  alu_op;
  logic        alu_en;
  logic [2:0]  bus_sel;
  logic        ld_ar, inr_ar, ld_pc, inr_pc, ld_dr, inr_dr, ld_ac, ld_ir;
  logic        ld_ac_inpr, ld_outr, clr_fgi, clr_fgo, clr_e, cmp_e;
  logic        mem_rd, mem_wr;
  logic [2:0]  sc;
  logic        halted;

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] S_LD_AR   = 16'h8000;
  localparam logic [15:0] S_INR_AR  = 16'h4000;
  localparam logic [15:0] S_LD_PC   = 16'h2000;
  localparam logic [15:0] S_INR_PC  = 16'h1000;
  localparam logic [15:0] S_LD_DR   = 16'h0800;
  localparam logic [15:0] S_INR_DR  = 16'h0400;
  localparam logic [15:0] S_LD_AC   = 16'h0200;
  localparam logic [15:0] S_LD_IR   = 16'h0100;
  localparam logic [15:0] S_LD_OUTR = 16'h0040;
  localparam logic [15:0] S_CLR_FGO = 16'h0010;
  localparam logic [15:0] S_MEM_RD  = 16'h0002;
  localparam logic [15:0] S_MEM_WR  = 16'h0001;

  logic [15:0] strobes;
  assign strobes = {ld_ar, inr_ar, ld_pc, inr_pc, ld_dr, inr_dr, ld_ac, ld_ir,
                    ld_ac_inpr, ld_outr, clr_fgi, clr_fgo, clr_e, cmp_e, mem_rd, mem_wr};

  mano_control_unit #(
    .ADDR_W (12),
    .SC_W   (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir         (ir),
    .ac_sign    (ac_sign),
    .ac_zero    (ac_zero),
    .dr_zero    (dr_zero),
    .e_flag     (e_flag),
    .fgi        (fgi),
    .fgo        (fgo),
    .alu_op     (alu_op),
    .alu_en     (alu_en),
    .bus_sel    (bus_sel),
    .ld_ar      (ld_ar),
    .inr_ar     (inr_ar),
    .ld_pc      (ld_pc),
    .inr_pc     (inr_pc),
    .ld_dr      (ld_dr),
    .inr_dr     (inr_dr),
    .ld_ac      (ld_ac),
    .ld_ir      (ld_ir),
    .ld_ac_inpr (ld_ac_inpr),
    .ld_outr    (ld_outr),
    .clr_fgi    (clr_fgi),
    .clr_fgo    (clr_fgo),
    .clr_e      (clr_e),
    .cmp_e      (cmp_e),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .sc         (sc),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic rstN, input logic [15:0] irVal,
                               input logic acSign, input logic drZero);
    rst_n   = rstN;
    ir      = irVal;
    ac_sign = acSign;
    dr_zero = drZero;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // alu_op is only meaningful while alu_en is high
  task automatic checkState(input string tag, input int expSc, input int expBus,
                            input logic expAluEn, input int expAluOp,
                            input logic [15:0] expStr, input logic expHalt);
    checkOutput({tag, ".sc"}, 16'(sc), 16'(expSc));
    checkOutput({tag, ".bus_sel"}, 16'(bus_sel), 16'(expBus));
    checkOutput({tag, ".alu_en"}, 16'(alu_en), 16'(expAluEn));
    if (expAluEn) checkOutput({tag, ".alu_op"}, 16'(alu_op), 16'(expAluOp));
    checkOutput({tag, ".strobes"}, strobes, expStr);
    checkOutput({tag, ".halted"}, 16'(halted), 16'(expHalt));
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  // T1 and T2 are identical for every instruction
  task automatic runFetch(input string tag);
    stepCycle();
    checkState({tag, ".T1"}, 1, 7, 1'b0, 0, S_LD_IR | S_INR_PC | S_MEM_RD, 1'b0);
    stepCycle();
    checkState({tag, ".T2"}, 2, 5, 1'b0, 0, S_LD_AR, 1'b0);
  endtask

  task automatic checkT0(input string tag);
    checkState({tag, ".T0"}, 0, 2, 1'b0, 0, S_LD_AR, 1'b0);
  endtask

  initial begin
    e_flag = 1'b0;
    ac_zero = 1'b0;
    fgi = 1'b0;
    fgo = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    $display("[TB] reset state");
    checkState("reset", 0, 2, 1'b0, 0, S_LD_AR, 1'b0);

    $display("[TB] LDA direct");
    applyStimulus(1'b1, 16'h2005, 1'b0, 1'b0);
    #1;
    checkT0("lda");
    runFetch("lda");
    stepCycle();
    checkState("lda.T3", 3, 0, 1'b0, 0, 16'h0000, 1'b0);
    stepCycle();
    checkState("lda.T4", 4, 7, 1'b0, 0, S_MEM_RD | S_LD_DR, 1'b0);
    stepCycle();
    checkState("lda.T5", 5, 0, 1'b1, 2, S_LD_AC, 1'b0);
    stepCycle();
    checkT0("lda.end");

    $display("[TB] LDA indirect");
    applyStimulus(1'b1, 16'hA005, 1'b0, 1'b0);
    runFetch("ldai");
    stepCycle();
    checkState("ldai.T3", 3, 7, 1'b0, 0, S_MEM_RD | S_LD_AR, 1'b0);
    stepCycle();
    checkState("ldai.T4", 4, 7, 1'b0, 0, S_MEM_RD | S_LD_DR, 1'b0);
    stepCycle();
    checkState("ldai.T5", 5, 0, 1'b1, 2, S_LD_AC, 1'b0);
    stepCycle();
    checkT0("ldai.end");

    $display("[TB] ISZ with DR zero, then nonzero");
    for (int pass = 0; pass < 2; pass++) begin
      applyStimulus(1'b1, 16'h6010, 1'b0, 1'b0);
      runFetch("isz");
      stepCycle();
      checkState("isz.T3", 3, 0, 1'b0, 0, 16'h0000, 1'b0);
      stepCycle();
      checkState("isz.T4", 4, 7, 1'b0, 0, S_MEM_RD | S_LD_DR, 1'b0);
      stepCycle();
      checkState("isz.T5", 5, 0, 1'b0, 0, S_INR_DR, 1'b0);
      applyStimulus(1'b1, 16'h6010, 1'b0, (pass == 0));
      stepCycle();
      if (pass == 0) checkState("isz.T6z", 6, 3, 1'b0, 0, S_MEM_WR | S_INR_PC, 1'b0);
      else           checkState("isz.T6nz", 6, 3, 1'b0, 0, S_MEM_WR, 1'b0);
      stepCycle();
      checkT0("isz.end");
    end

    $display("[TB] SNA with AC negative, then positive");
    applyStimulus(1'b1, 16'h7008, 1'b1, 1'b0);
    runFetch("sna1");
    stepCycle();
    checkState("sna1.T3", 3, 0, 1'b0, 0, S_INR_PC, 1'b0);
    stepCycle();
    checkT0("sna1.end");
    applyStimulus(1'b1, 16'h7008, 1'b0, 1'b0);
    runFetch("sna0");
    stepCycle();
    checkState("sna0.T3", 3, 0, 1'b0, 0, 16'h0000, 1'b0);
    stepCycle();
    checkT0("sna0.end");

    $display("[TB] CLA+INC: only CLA acts");
    applyStimulus(1'b1, 16'h7820, 1'b0, 1'b0);
    runFetch("cla");
    stepCycle();
    checkState("cla.T3", 3, 0, 1'b1, 6, S_LD_AC, 1'b0);
    stepCycle();
    checkT0("cla.end");

    $display("[TB] OUT");
    applyStimulus(1'b1, 16'hF400, 1'b0, 1'b0);
    runFetch("out");
    stepCycle();
    checkState("out.T3", 3, 4, 1'b0, 0, S_LD_OUTR | S_CLR_FGO, 1'b0);
    stepCycle();
    checkT0("out.end");

    $display("[TB] STA");
    applyStimulus(1'b1, 16'h3005, 1'b0, 1'b0);
    runFetch("sta");
    stepCycle();
    stepCycle();
    checkState("sta.T4", 4, 4, 1'b0, 0, S_MEM_WR, 1'b0);
    stepCycle();
    checkT0("sta.end");

    $display("[TB] BSA");
    applyStimulus(1'b1, 16'h5005, 1'b0, 1'b0);
    runFetch("bsa");
    stepCycle();
    stepCycle();
    checkState("bsa.T4", 4, 2, 1'b0, 0, S_MEM_WR | S_INR_AR, 1'b0);
    stepCycle();
    checkState("bsa.T5", 5, 1, 1'b0, 0, S_LD_PC, 1'b0);
    stepCycle();
    checkT0("bsa.end");

    $display("[TB] reset during ADD T5");
    applyStimulus(1'b1, 16'h1005, 1'b0, 1'b0);
    runFetch("add");
    stepCycle();
    stepCycle();
    checkState("add.T4", 4, 7, 1'b0, 0, S_MEM_RD | S_LD_DR, 1'b0);
    stepCycle();
    checkState("add.T5", 5, 0, 1'b1, 1, S_LD_AC, 1'b0);
    applyStimulus(1'b0, 16'h1005, 1'b0, 1'b0);
    #1;
    checkState("add.T5rst", 5, 2, 1'b0, 0, S_LD_AR, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 16'h1005, 1'b0, 1'b0);
    #1;
    checkT0("add.after");

    $display("[TB] HLT");
    applyStimulus(1'b1, 16'h7001, 1'b0, 1'b0);
    runFetch("hlt");
    stepCycle();
    checkState("hlt.T3", 3, 0, 1'b0, 0, 16'h0000, 1'b0);
    for (int k = 0; k < 10; k++) begin
      stepCycle();
      checkState($sformatf("hlt.hold%0d", k), 0, 0, 1'b0, 0, 16'h0000, 1'b1);
    end
    applyStimulus(1'b0, 16'h7001, 1'b0, 1'b0);
    stepCycle();
    checkState("hlt.rst", 0, 2, 1'b0, 0, S_LD_AR, 1'b0);
    applyStimulus(1'b1, 16'h2005, 1'b0, 1'b0);
    runFetch("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mano_control_unit.md
Name: mano_control_unit

Overview:
Timing and control sequencer for the basic computer, directly upstream of the ALU. It runs the fetch/decode/execute sequence with a 3-bit sequence counter (T0..T6) and decodes IR. Every cycle it drives the ALU opcode and enable, the bus source select, the register load/increment strobes and the memory read/write strobes. All outputs are Moore-style decodes of registered state (SC, I-bit, IR) plus the listed status inputs.

Parameters:
ADDR_W, 12, address field width taken from IR[ADDR_W-1:0]
SC_W, 3, sequence-counter width; the maximum state used is T6

Ports:
clk  in  1  system clock; every register updates on the rising edge
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
ir  in  16  instruction register contents: [15]=I, [14:12]=opcode, [11:0]=address/ref bits
ac_sign, ac_zero, dr_zero, e_flag  in  1 each  status from AC, DR and the E flip-flop
fgi, fgo  in  1 each  input/output ready flags
alu_op  out  3  0 AND, 1 ADD, 2 pass DR, 3 CMA, 4 CIR, 5 CIL, 6 CLA, 7 INC
alu_en  out  1  ALU result valid this cycle
bus_sel  out  3  0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
ld_ar, inr_ar, ld_pc, inr_pc, ld_dr, inr_dr, ld_ac, ld_ir  out  1 each  register strobes
ld_ac_inpr, ld_outr, clr_fgi, clr_fgo, clr_e, cmp_e  out  1 each  I/O strobes and E-flag strobes
mem_rd, mem_wr  out  1 each  memory strobes
sc  out  3  current sequence count (debug)
halted  out  1  sticky halt indicator

Behaviour:
- Reset (rst_n=0 at an edge): sc=0, halted=0, the internal latched I bit i_q=0, the interrupt flops cleared. All strobes are combinational decodes of state; every strobe is 0 except those required by T0.
- Reset mid-instruction abandons the instruction. The next cycle is T0.
- Only one bus_sel value is driven per cycle. Strobes not listed for a state are 0.
- T0: bus_sel=PC, ld_ar.
- T1: mem_rd, bus_sel=MEM, ld_ir, inr_pc.
- T2: i_q<=ir[15]; bus_sel=IR, ld_ar (AR<=IR[11:0]).
- T3:
  - Memory-reference instruction (opcode!=7) with I=1: mem_rd, bus_sel=MEM, ld_ar.
  - Memory-reference instruction with I=0: idle.
  - opcode=7, I=0 (register reference): execute and reset SC. Only the highest-numbered set bit of ir[11:0] acts.
    - CLA: alu_op=6, alu_en, ld_ac.
    - CLE: clr_e. CME: cmp_e.
    - CMA: alu_op=3. CIR: alu_op=4. CIL: alu_op=5. INC: alu_op=7. Each of these also asserts alu_en and ld_ac.
    - SPA: inr_pc if !ac_sign. SNA: inr_pc if ac_sign. SZA: inr_pc if ac_zero. SZE: inr_pc if !e_flag.
    - HLT: halted<=1.
  - opcode=7, I=1 (I/O): execute and reset SC.
    - INP (bit 11): ld_ac_inpr, clr_fgi.
    - OUT (bit 10): bus_sel=AC, ld_outr, clr_fgo.
    - SKI (bit 9): inr_pc if fgi. SKO (bit 8): inr_pc if fgo.
    - ION/IOF (bits 7, 6): handled per the optional feature below.
- T4 (memory reference):
  - AND/ADD/LDA/ISZ: mem_rd, bus_sel=MEM, ld_dr.
  - STA: bus_sel=AC, mem_wr, SC<=0.
  - BUN: bus_sel=AR, ld_pc, SC<=0.
  - BSA: bus_sel=PC, mem_wr, inr_ar.
- T5:
  - AND: alu_op=0. ADD: alu_op=1. LDA: alu_op=2. Each asserts alu_en and ld_ac, then SC<=0. The ALU latches its carry into E on this same edge.
  - BSA: bus_sel=AR, ld_pc, SC<=0.
  - ISZ: inr_dr.
- T6 (ISZ only): bus_sel=DR, mem_wr; inr_pc if dr_zero (DR after the T5 increment); SC<=0.
- Otherwise SC increments by 1 each cycle. SC never exceeds 6. An undefined SC value forces SC<=0.
- Halted: SC is held at 0 and every strobe is 0 until reset.
- Latency per instruction: register-ref/I-O 4 cycles; STA/BUN 5; AND/ADD/LDA/BSA 6; ISZ 7. Add 0 cycles for the indirect fetch, because it is absorbed in T3.

Optional Feature:
MANO_INTERRUPT_EN
- Defined:
  - Adds the ien and r flops, both reset to 0. ION sets ien; IOF clears it.
  - When SC is not 0 or 1 or 2, ien=1 and (fgi|fgo), r<=1 at the clock edge.
  - When r=1, the cycle runs in place of fetch:
    - RT0: bus_sel=none, AR<=0, TR<=PC.
    - RT1: M[AR]<=TR, PC<=0.
    - RT2: inr_pc, ien<=0, r<=0, SC<=0.
- Undefined: ION/IOF are NOPs that reset SC; no interrupt cycle exists.

Decomposition:
Shared package mano_pkg holds:
- the alu_op encodings
- the bus_sel encodings
- the memory-reference opcode constants (AND=0 .. ISZ=6, REG/IO=7)
- the register-ref and I/O bit indices

mano_seq_counter is the natural sub-module: SC with inc, clr and hold inputs, plus a one-hot T0..T6 decode.

Test Plan:
- Reset, then ir=16'h2005 (LDA 5, direct). Required: T0 ld_ar/bus_sel=2; T1 ld_ir/inr_pc; T4 ld_dr; T5 alu_op=2, ld_ac; sc returns to 0 after 6 cycles.
- ir=16'hA005 (LDA indirect). Required: T3 mem_rd with bus_sel=7 and ld_ar; timing otherwise identical to the first case.
- ir=16'h6010 (ISZ) with dr_zero=1 at T6. Required: mem_wr and inr_pc at T6. With dr_zero=0: mem_wr only.
- ir=16'h7008 (SNA) with ac_sign=1, then with ac_sign=0. Required: inr_pc asserted at T3 in the first case only; sc=0 in the next cycle in both cases.
- ir=16'h7001 (HLT). Required: halted=1, strobes stay 0 for 10 cycles; rst_n=0 clears halted.
- rst_n=0 asserted during T5 of ADD. Required: no ld_ac on that edge; next state T0.
